// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {
    MOORE = 1'b0,
    MEALY = 1'b1
  } mode_t;

  localparam int unsigned MAX_W = 16;

  // Out-of-range lengths (0 or above the history width) fall back to the full width.
  function automatic int unsigned len_clamp(input int unsigned len, input int unsigned w);
    int unsigned r;
    if ((len < 32'd1) || (len > w)) begin
      r = w;
    end else begin
      r = len;
    end
    return r;
  endfunction

  // Mask with the low 'len' bits set; callers cast it down to their width.
  function automatic logic [MAX_W-1:0] make_mask(input int unsigned len);
    logic [MAX_W-1:0] m;
    m = {MAX_W{1'b0}};
    for (int unsigned i = 0; i < MAX_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Masked comparator: the candidate history matches when enough bits are
// present and the low 'len' bits equal the pattern.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int W  = 8,
  parameter int LW = $clog2(W + 1)
) (
  input  logic [W-1:0]  nhist,
  input  logic [W-1:0]  pat,
  input  logic [LW-1:0] len,
  input  logic [LW-1:0] nfill,
  output logic          eq
);

  logic [W-1:0] mask_s;

  // Build the length mask and compare the masked history against the pattern.
  always_comb begin
    mask_s = W'(make_mask(32'(len)));
    eq     = (nfill >= len) && ((nhist & mask_s) == (pat & mask_s));
  end

endmodule

// File: rtl/seq_detector.sv
// Parametrised serial bit-pattern detector with Moore/Mealy match pulse,
// optional overlap and a saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int           W       = 8,
  parameter mode_t        MODE    = MOORE,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CW      = 8,
  parameter logic [W-1:0] PAT_RST = W'(3'b101),
  parameter int           LEN_RST = 3
) (
  input  logic                     CLK,
  input  logic                     Rst,
  input  logic                     b,
  input  logic                     b_valid,
  input  logic                     pat_load,
  input  logic [W-1:0]             pat_in,
  input  logic [$clog2(W+1)-1:0]   len_in,
  input  logic                     cnt_clr,
  output logic                     x,
  output logic [CW-1:0]            match_cnt,
  output logic                     armed
);

  localparam int LW = $clog2(W + 1);

  logic [W-1:0]  hist_r;
  logic [LW-1:0] fill_r;
  logic [W-1:0]  pat_r;
  logic [LW-1:0] len_r;
  logic          x_q_r;
  logic [CW-1:0] cnt_r;
  logic          armed_r;

  logic          accept_s;
  logic [W-1:0]  nhist_s;
  logic [LW-1:0] nfill_s;
  logic          eq_s;
  logic          hit_s;
  logic [W-1:0]  hist_nx_s;
  logic [LW-1:0] fill_nx_s;
  logic [W-1:0]  pat_nx_s;
  logic [LW-1:0] len_nx_s;

  // Candidate history/fill if the presented bit were accepted; a load drops the bit.
  always_comb begin
    accept_s = b_valid & ~pat_load;
    nhist_s  = {hist_r[W-2:0], b};
    if (fill_r == LW'(W)) begin
      nfill_s = fill_r;
    end else begin
      nfill_s = fill_r + LW'(1'b1);
    end
  end

  seq_det_match #(
    .W  (W),
    .LW (LW)
  ) u_match (
    .nhist (nhist_s),
    .pat   (pat_r),
    .len   (len_r),
    .nfill (nfill_s),
    .eq    (eq_s)
  );

  // Hit is gated by reset so a Mealy pulse can never appear while Rst is high.
  always_comb begin
    hit_s = accept_s & eq_s & ~Rst;
  end

  // Next-state selection: load has priority, then accepted bits, otherwise hold.
  always_comb begin
    hist_nx_s = hist_r;
    fill_nx_s = fill_r;
    pat_nx_s  = pat_r;
    len_nx_s  = len_r;
    if (pat_load) begin
      pat_nx_s  = pat_in;
      len_nx_s  = LW'(len_clamp(32'(len_in), 32'(W)));
      hist_nx_s = {W{1'b0}};
      fill_nx_s = {LW{1'b0}};
    end else if (accept_s) begin
      hist_nx_s = nhist_s;
      if (hit_s && !OVERLAP) begin
        fill_nx_s = {LW{1'b0}};
      end else begin
        fill_nx_s = nfill_s;
      end
    end else begin
      hist_nx_s = hist_r;
      fill_nx_s = fill_r;
    end
  end

  // State, registered match pulse, armed flag and saturating counter.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      hist_r  <= {W{1'b0}};
      fill_r  <= {LW{1'b0}};
      pat_r   <= PAT_RST;
      len_r   <= LW'(len_clamp(32'(LEN_RST), 32'(W)));
      x_q_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      armed_r <= 1'b0;
    end else begin
      hist_r  <= hist_nx_s;
      fill_r  <= fill_nx_s;
      pat_r   <= pat_nx_s;
      len_r   <= len_nx_s;
      x_q_r   <= hit_s;
      armed_r <= (fill_nx_s >= len_nx_s);
      if (cnt_clr) begin
        cnt_r <= {CW{1'b0}};
      end else if (hit_s && (cnt_r != {CW{1'b1}})) begin
        cnt_r <= cnt_r + CW'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Output timing selection: registered pulse or same-cycle hit.
  always_comb begin
    if (MODE == MEALY) begin
      x = hit_s;
    end else begin
      x = x_q_r;
    end
  end

  assign match_cnt = cnt_r;
  assign armed     = armed_r;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: three instances (Moore/overlap/CW=2,
// Moore/no-overlap, Mealy/overlap). Each stimulus step pushes the expected
// outputs for that cycle; a negedge monitor pops and compares.
module tb_seq_detector;
  import seq_det_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst [3];
  logic       b   [3];
  logic       bv  [3];
  logic       ld  [3];
  logic       clr [3];
  logic [7:0] pin [3];
  logic [3:0] lin [3];

  logic       x0, x1, x2;
  logic       a0, a1, a2;
  logic [1:0] cnt0;
  logic [7:0] cnt1, cnt2;

  seq_detector #(.W(8), .MODE(MOORE), .OVERLAP(1'b1), .CW(2)) u0 (
    .CLK(CLK), .Rst(rst[0]), .b(b[0]), .b_valid(bv[0]), .pat_load(ld[0]),
    .pat_in(pin[0]), .len_in(lin[0]), .cnt_clr(clr[0]),
    .x(x0), .match_cnt(cnt0), .armed(a0));

  seq_detector #(.W(8), .MODE(MOORE), .OVERLAP(1'b0), .CW(8)) u1 (
    .CLK(CLK), .Rst(rst[1]), .b(b[1]), .b_valid(bv[1]), .pat_load(ld[1]),
    .pat_in(pin[1]), .len_in(lin[1]), .cnt_clr(clr[1]),
    .x(x1), .match_cnt(cnt1), .armed(a1));

  seq_detector #(.W(8), .MODE(MEALY), .OVERLAP(1'b1), .CW(8)) u2 (
    .CLK(CLK), .Rst(rst[2]), .b(b[2]), .b_valid(bv[2]), .pat_load(ld[2]),
    .pat_in(pin[2]), .len_in(lin[2]), .cnt_clr(clr[2]),
    .x(x2), .match_cnt(cnt2), .armed(a2));

  typedef struct {
    int         d;
    int         tag;
    logic       ex;
    logic [7:0] ecnt;
    logic       ea;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   stepn  = 0;

  task automatic chk(input string name, input int tag, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, want);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare the selected instance.
  always @(negedge CLK) begin
    exp_t       e;
    logic       ax;
    logic       aa;
    logic [7:0] ac;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.d)
        0: begin ax = x0; aa = a0; ac = {6'b000000, cnt0}; end
        1: begin ax = x1; aa = a1; ac = cnt1; end
        default: begin ax = x2; aa = a2; ac = cnt2; end
      endcase
      chk($sformatf("x[u%0d]", e.d), e.tag, {7'b0000000, ax}, {7'b0000000, e.ex});
      chk($sformatf("match_cnt[u%0d]", e.d), e.tag, ac, e.ecnt);
      chk($sformatf("armed[u%0d]", e.d), e.tag, {7'b0000000, aa}, {7'b0000000, e.ea});
    end
  end

  // Drive one cycle of inputs on instance d and queue the outputs expected in that cycle.
  task automatic st(input int d, input logic r, input logic bi, input logic vi, input logic li,
                    input logic [7:0] p, input logic [3:0] l, input logic c,
                    input logic ex, input logic [7:0] ec, input logic ea);
    exp_t e;
    @(posedge CLK);
    #1;
    rst[d] = r; b[d] = bi; bv[d] = vi; ld[d] = li; pin[d] = p; lin[d] = l; clr[d] = c;
    e.d = d; e.tag = stepn; e.ex = ex; e.ecnt = ec; e.ea = ea;
    stepn++;
    q.push_back(e);
  endtask

  task automatic sb(input int d, input logic bi, input logic ex, input logic [7:0] ec, input logic ea);
    st(d, 1'b0, bi, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, ex, ec, ea);
  endtask

  task automatic si(input int d, input logic ex, input logic [7:0] ec, input logic ea);
    st(d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, ex, ec, ea);
  endtask

  initial begin
    logic [7:0] pv;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; b[i] = 1'b0; bv[i] = 1'b0; ld[i] = 1'b0;
      pin[i] = 8'h00; lin[i] = 4'd0; clr[i] = 1'b0;
    end
    repeat (2) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // u0: Moore, overlap, pattern 101: stream 1,0,1,0,1
    sb(0, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(0, 1'b0, 1'b0, 8'd0, 1'b0);
    sb(0, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(0, 1'b0, 1'b1, 8'd1, 1'b1);
    sb(0, 1'b1, 1'b0, 8'd1, 1'b1);
    si(0, 1'b1, 8'd2, 1'b1);
    si(0, 1'b0, 8'd2, 1'b1);
    // u0: more hits saturate the 2-bit counter, then clear collides with a hit
    sb(0, 1'b0, 1'b0, 8'd2, 1'b1);
    sb(0, 1'b1, 1'b0, 8'd2, 1'b1);
    sb(0, 1'b0, 1'b1, 8'd3, 1'b1);
    sb(0, 1'b1, 1'b0, 8'd3, 1'b1);
    sb(0, 1'b0, 1'b1, 8'd3, 1'b1);
    st(0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 8'd3, 1'b1);
    si(0, 1'b1, 8'd0, 1'b1);
    si(0, 1'b0, 8'd0, 1'b1);
    // u0: reset mid-stream (1,0 then Rst with a would-be completing 1)
    sb(0, 1'b1, 1'b0, 8'd0, 1'b1);
    sb(0, 1'b0, 1'b0, 8'd0, 1'b1);
    st(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    sb(0, 1'b1, 1'b0, 8'd0, 1'b0);
    si(0, 1'b0, 8'd0, 1'b0);
    si(0, 1'b0, 8'd0, 1'b0);

    // u1: Moore, no overlap: stream 1,0,1,0,1 gives a single hit
    sb(1, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(1, 1'b0, 1'b0, 8'd0, 1'b0);
    sb(1, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(1, 1'b0, 1'b1, 8'd1, 1'b0);
    sb(1, 1'b1, 1'b0, 8'd1, 1'b0);
    si(1, 1'b0, 8'd1, 1'b0);
    si(1, 1'b0, 8'd1, 1'b0);
    // u1: b_valid gaps (b toggles while invalid) do not break 1,0,1
    sb(1, 1'b1, 1'b0, 8'd1, 1'b0);
    si(1, 1'b0, 8'd1, 1'b1);
    st(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd1, 1'b1);
    si(1, 1'b0, 8'd1, 1'b1);
    sb(1, 1'b0, 1'b0, 8'd1, 1'b1);
    st(1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd1, 1'b1);
    sb(1, 1'b1, 1'b0, 8'd1, 1'b1);
    si(1, 1'b1, 8'd2, 1'b0);
    si(1, 1'b0, 8'd2, 1'b0);
    // u1: len=1 pattern 1, no overlap still hits every 1
    st(1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 8'd2, 1'b0);
    sb(1, 1'b1, 1'b0, 8'd2, 1'b0);
    sb(1, 1'b1, 1'b1, 8'd3, 1'b0);
    sb(1, 1'b0, 1'b1, 8'd4, 1'b0);
    sb(1, 1'b1, 1'b0, 8'd4, 1'b1);
    si(1, 1'b1, 8'd5, 1'b0);
    si(1, 1'b0, 8'd5, 1'b0);
    // u1: len_in=0 clamps to 8; pattern A5 needs all eight bits
    st(1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd0, 1'b0, 1'b0, 8'd5, 1'b0);
    pv = 8'hA5;
    for (int i = 7; i >= 0; i--) sb(1, pv[i], 1'b0, 8'd5, 1'b0);
    si(1, 1'b1, 8'd6, 1'b0);
    si(1, 1'b0, 8'd6, 1'b0);

    // u2: Mealy, pattern 0110 len 4, stream 0,1,1,0
    st(2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 4'd4, 1'b0, 1'b0, 8'd0, 1'b0);
    sb(2, 1'b0, 1'b0, 8'd0, 1'b0);
    sb(2, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(2, 1'b1, 1'b0, 8'd0, 1'b0);
    sb(2, 1'b0, 1'b1, 8'd0, 1'b0);
    si(2, 1'b0, 8'd1, 1'b1);
    // u2: load 11/len2 with b_valid high drops the bit; 1,1,1,1 then back-to-back hits
    st(2, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd2, 1'b0, 1'b0, 8'd1, 1'b1);
    sb(2, 1'b1, 1'b0, 8'd1, 1'b0);
    sb(2, 1'b1, 1'b1, 8'd1, 1'b0);
    sb(2, 1'b1, 1'b1, 8'd2, 1'b1);
    sb(2, 1'b1, 1'b1, 8'd3, 1'b1);
    // u2: Rst with a would-be hit: x gated low, then everything cleared
    st(2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 8'd4, 1'b1);
    si(2, 1'b0, 8'd0, 1'b0);
    si(2, 1'b0, 8'd0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; (i < 10) && (q.size() > 0); i++) @(posedge CLK);
    @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
